// File: rtl/adder_pkg.sv
// Shared constants, stage-count derivation and op-select encoding for the pipelined adder.
package adder_pkg;

   localparam int unsigned DefWidth = 128;
   localparam int unsigned DefSeg   = 32;

   typedef enum logic {
      OpAdd = 1'b0,
      OpSub = 1'b1
   } op_e;

   function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
      return width / seg;
   endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: adds slice Idx of the operands plus the incoming carry and registers
// the carry, the partial sum and the pass-through operands; holds everything while en_i=0.
module adder_seg_stage
   import adder_pkg::*;
#(
   parameter int unsigned Width = DefWidth,
   parameter int unsigned Seg   = DefSeg,
   parameter int unsigned Idx   = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic             carry_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic [Width-1:0] sum_i,
   output logic             valid_o,
   output logic             carry_o,
   output logic [Width-1:0] a_o,
   output logic [Width-1:0] b_o,
   output logic [Width-1:0] sum_o
);

   logic             valid_d, valid_q;
   logic             carry_d, carry_q;
   logic [Width-1:0] a_d, a_q;
   logic [Width-1:0] b_d, b_q;
   logic [Width-1:0] sum_d, sum_q;
   logic [Seg:0]     slice_sum;

   always_comb begin
      slice_sum = {1'b0, a_i[Idx*Seg +: Seg]} + {1'b0, b_i[Idx*Seg +: Seg]}
                  + {{Seg{1'b0}}, carry_i};
      valid_d = valid_i;
      carry_d = slice_sum[Seg];
      a_d     = a_i;
      b_d     = b_i;
      // Lower slices arrive already summed; only this stage's slice is filled in.
      sum_d                  = sum_i;
      sum_d[Idx*Seg +: Seg]  = slice_sum[Seg-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else if (en_i) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign valid_o = valid_q;
   assign carry_o = carry_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign sum_o   = sum_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, one SEG-bit ripple segment per stage, valid/ready on both sides.
// Define ADDER_SUB_EN to add the `sub` port (out0 = in0 - in1, out1 = not-borrow).
module adder_pipe
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned SEG   = DefSeg
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out0,
   output logic             out1
);

   localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);

   if ((SEG == 0) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
      $error("adder_pipe: WIDTH must be a non-zero multiple of SEG");
   end

   logic             en;
   logic             carry_in;
   logic [WIDTH-1:0] b_in;
   logic [NSEG:0]    valid_s;
   logic [NSEG:0]    carry_s;
   logic [WIDTH-1:0] a_s   [NSEG+1];
   logic [WIDTH-1:0] b_s   [NSEG+1];
   logic [WIDTH-1:0] sum_s [NSEG+1];

   always_comb begin
      en = !valid_s[NSEG] || out_ready;
`ifdef ADDER_SUB_EN
      // Subtract as in0 + ~in1 + 1; the inverted operand and carry-in travel with the op.
      b_in     = (op_e'(sub) == OpSub) ? ~in1 : in1;
      carry_in = sub;
`else
      b_in     = in1;
      carry_in = 1'b0;
`endif
   end

   assign in_ready   = en;
   assign valid_s[0] = in_valid;
   assign carry_s[0] = carry_in;
   assign a_s[0]     = in0;
   assign b_s[0]     = b_in;
   assign sum_s[0]   = '0;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      adder_seg_stage #(
         .Width (WIDTH),
         .Seg   (SEG),
         .Idx   (k)
      ) u_stage (
         .clk_i   (clk),
         .rst_i   (rst),
         .en_i    (en),
         .valid_i (valid_s[k]),
         .carry_i (carry_s[k]),
         .a_i     (a_s[k]),
         .b_i     (b_s[k]),
         .sum_i   (sum_s[k]),
         .valid_o (valid_s[k+1]),
         .carry_o (carry_s[k+1]),
         .a_o     (a_s[k+1]),
         .b_o     (b_s[k+1]),
         .sum_o   (sum_s[k+1])
      );
   end

   // Operands leaving the last stage are fully consumed.
   logic unused_pass;
   assign unused_pass = ^{a_s[NSEG], b_s[NSEG]};

   assign out_valid = valid_s[NSEG];
   assign out0      = sum_s[NSEG];
   assign out1      = carry_s[NSEG];

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe at default WIDTH=128, SEG=32 (4 stages).
module tb_adder_pipe;

   localparam int unsigned WIDTH = 128;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] in0       = '0;
   logic [WIDTH-1:0] in1       = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out0;
   logic             out1;
`ifdef ADDER_SUB_EN
   logic             sub       = 1'b0;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [WIDTH-1:0] sa [3];
   logic [WIDTH-1:0] sb [3];
   logic [WIDTH-1:0] se [3];
   logic             sc [3];

   always #5 clk = ~clk;

   adder_pipe u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
`ifdef ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1)
   );

   task automatic check_eq(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      in_valid = v;
      in0      = a;
      in1      = b;
   endtask

   initial begin
      // Reset held 2 cycles with in_valid asserted.
      drive(1'b1, 128'd5, 128'd6);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_out_valid", out_valid, 0);
         check_eq("rst_out0", out0, 0);
         check_eq("rst_out1", out1, 0);
      end
      rst = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_idle_valid", out_valid, 0);

      // Carry ripple across all segments.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b1, {WIDTH{1'b1}}, 128'd1);
         else if (i == 1) drive(1'b0, '0, '0);
         if (i >= 1 && i <= 3) check_eq("ripple_early_valid", out_valid, 0);
         if (i == 4) begin
            check_eq("ripple_valid", out_valid, 1);
            check_eq("ripple_out0", out0, 0);
            check_eq("ripple_out1", out1, 1);
         end
      end

      // Back-to-back streaming.
      sa[0] = 128'd1;  sb[0] = 128'd2;  se[0] = 128'd3;  sc[0] = 1'b0;
      sa[1] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
      sb[1] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
      se[1] = 128'd0;  sc[1] = 1'b1;
      sa[2] = 128'hFFFF_FFFF;  sb[2] = 128'd1;  se[2] = 128'h1_0000_0000;  sc[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 4 && i <= 6) begin
            check_eq($sformatf("stream%0d_valid", i - 4), out_valid, 1);
            check_eq($sformatf("stream%0d_out0", i - 4), out0, se[i-4]);
            check_eq($sformatf("stream%0d_out1", i - 4), out1, sc[i-4]);
         end
         if (i == 7) check_eq("stream_drained", out_valid, 0);
         if (i < 3) drive(1'b1, sa[i], sb[i]);
         else drive(1'b0, '0, '0);
      end

      // Backpressure: result 30 held 3 cycles; bubble behind op 3 must survive.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         case (i)
            0: drive(1'b1, 128'd10, 128'd20);
            1: drive(1'b1, 128'd100, 128'd200);
            2: drive(1'b1, 128'd7, 128'd8);
            3: begin drive(1'b0, '0, '0); out_ready = 1'b0; end
            4, 5, 6: begin
               check_eq("stall_valid", out_valid, 1);
               check_eq("stall_out0", out0, 128'd30);
               check_eq("stall_in_ready", in_ready, 0);
               if (i == 6) begin
                  out_ready = 1'b1;
                  drive(1'b1, 128'd55, 128'd45);
                  #1;
                  check_eq("release_in_ready", in_ready, 1);
               end
            end
            7: begin
               check_eq("drain0_valid", out_valid, 1);
               check_eq("drain0_out0", out0, 128'd300);
               drive(1'b0, '0, '0);
            end
            8: begin
               check_eq("drain1_valid", out_valid, 1);
               check_eq("drain1_out0", out0, 128'd15);
            end
            9: check_eq("drain_bubble", out_valid, 0);
            10: begin
               check_eq("drain2_valid", out_valid, 1);
               check_eq("drain2_out0", out0, 128'd100);
            end
            default: check_eq("drain_done", out_valid, 0);
         endcase
      end

      // Mid-flight reset discards both in-flight ops.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i >= 3 && i <= 7) check_eq("midrst_valid", out_valid, 0);
         case (i)
            0: drive(1'b1, 128'd1, 128'd1);
            1: drive(1'b1, 128'd2, 128'd2);
            2: begin drive(1'b0, '0, '0); rst = 1'b1; end
            4: begin rst = 1'b0; drive(1'b1, 128'd9, 128'd4); end
            5: drive(1'b0, '0, '0);
            8: begin
               check_eq("postrst_valid", out_valid, 1);
               check_eq("postrst_out0", out0, 128'd13);
            end
            default: ;
         endcase
      end

`ifdef ADDER_SUB_EN
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         case (i)
            0: begin sub = 1'b1; drive(1'b1, 128'd5, 128'd7); end
            1: drive(1'b1, 128'd7, 128'd5);
            2: begin sub = 1'b0; drive(1'b0, '0, '0); end
            4: begin
               check_eq("sub0_out0", out0, {{(WIDTH-1){1'b1}}, 1'b0});
               check_eq("sub0_out1", out1, 0);
            end
            5: begin
               check_eq("sub1_out0", out0, 128'd2);
               check_eq("sub1_out1", out1, 1);
            end
            default: ;
         endcase
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
